// File: rtl/memory_stage_pkg.sv
// Shared types and constants for the memory access stage.
package memory_stage_pkg;

  typedef enum logic [0:0] {IDLE, ACCESS} mem_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Size 2'b11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_HALF) && off[0]) || ((size[1] == 1'b1) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane steering for stores and extraction/extension for loads.
module load_store_align
  import memory_stage_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] rs2,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_offset,
  input  logic        ld_unsigned,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    be    = 4'b1111;
    wdata = rs2;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << offset;
        wdata = {4{rs2[7:0]}};
      end
      SZ_HALF: begin
        be    = 4'b0011 << offset;
        wdata = {2{rs2[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = rs2;
      end
    endcase
  end

  always_comb begin
    shifted   = rdata >> {ld_offset, 3'b000};
    load_data = rdata;
    case (ld_size)
      SZ_BYTE: load_data = ld_unsigned ? {24'b0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = ld_unsigned ? {16'b0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// Memory pipeline stage: req/ack data-bus access plus the Memory/Writeback register.
// Optional bus timeout enabled by defining MEM_TIMEOUT_EN.
module memory_access_stage
  import memory_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        MEMORY_CLOCK,
  input  logic        MEMORY_RESET,
  input  logic        EXEC_VALID,
  input  logic [31:0] EXEC_PC_4,
  input  logic [31:0] EXEC_ALU_RESULT,
  input  logic [31:0] EXEC_RS2,
  input  logic [1:0]  EXEC_RF_WR_SEL,
  input  logic        EXEC_REGWRITE,
  input  logic        EXEC_MEMWRITE,
  input  logic        EXEC_MEMREAD2,
  input  logic [1:0]  EXEC_SIZE,
  input  logic        EXEC_UNSIGNED,
  output logic        MEM_STALL,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_BE,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic        MEM_VALID,
  output logic [31:0] MEM_PC_4,
  output logic [31:0] MEM_ALU_RESULT,
  output logic [31:0] MEM_LOAD_DATA,
  output logic [1:0]  MEM_RF_WR_SEL,
  output logic        MEM_REGWRITE,
  output logic        MEM_MISALIGN,
  output logic        MEM_BUS_ERR
);

  if (64'(TIMEOUT_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES does not fit in CNT_W bits");
  end

  mem_state_t state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;

  // Pass-through fields held while the bus access is outstanding.
  logic [31:0] h_pc4_q, h_alu_q;
  logic [1:0]  h_sel_q, h_size_q;
  logic        h_regwrite_q, h_unsigned_q, h_store_q;

  logic        wb_valid_q, wb_regwrite_q, wb_misalign_q, wb_bus_err_q;
  logic [31:0] wb_pc4_q, wb_alu_q, wb_load_q;
  logic [1:0]  wb_sel_q;

  logic        accept, is_mem, misalign, start_access, retire_now, timeout, done;
  logic [3:0]  align_be;
  logic [31:0] align_wdata, align_load;

  load_store_align u_align (
    .size        (EXEC_SIZE),
    .offset      (EXEC_ALU_RESULT[1:0]),
    .rs2         (EXEC_RS2),
    .ld_size     (h_size_q),
    .ld_offset   (h_alu_q[1:0]),
    .ld_unsigned (h_unsigned_q),
    .rdata       (MEM_RDATA),
    .be          (align_be),
    .wdata       (align_wdata),
    .load_data   (align_load)
  );

  assign accept       = (state_q == IDLE) && EXEC_VALID;
  assign is_mem       = EXEC_MEMWRITE | EXEC_MEMREAD2;
  assign misalign     = is_mem && is_misaligned(EXEC_SIZE, EXEC_ALU_RESULT[1:0]);
  assign start_access = accept && is_mem && !misalign;
  assign retire_now   = accept && !start_access;
  assign done         = (state_q == ACCESS) && (MEM_ACK || timeout);

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;

  // MEM_ACK in the final cycle takes priority over the abort.
  assign timeout = (state_q == ACCESS) && !MEM_ACK && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge MEMORY_CLOCK) begin
    if (!MEMORY_RESET) begin
      cnt_q <= '0;
    end else if (start_access) begin
      cnt_q <= '0;
    end else if ((state_q == ACCESS) && !MEM_ACK) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    unique case (state_q)
      IDLE: begin
        if (start_access) begin
          state_d = ACCESS;
          req_d   = 1'b1;
          we_d    = EXEC_MEMWRITE;
          addr_d  = {EXEC_ALU_RESULT[31:2], 2'b00};
          wdata_d = align_wdata;
          be_d    = align_be;
        end
      end
      ACCESS: begin
        if (done) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge MEMORY_CLOCK) begin
    if (!MEMORY_RESET) begin
      state_q       <= IDLE;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      h_pc4_q       <= '0;
      h_alu_q       <= '0;
      h_sel_q       <= '0;
      h_size_q      <= '0;
      h_regwrite_q  <= 1'b0;
      h_unsigned_q  <= 1'b0;
      h_store_q     <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_pc4_q      <= '0;
      wb_alu_q      <= '0;
      wb_load_q     <= '0;
      wb_sel_q      <= '0;
      wb_regwrite_q <= 1'b0;
      wb_misalign_q <= 1'b0;
      wb_bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      wb_valid_q <= retire_now || done;
      if (start_access) begin
        h_pc4_q      <= EXEC_PC_4;
        h_alu_q      <= EXEC_ALU_RESULT;
        h_sel_q      <= EXEC_RF_WR_SEL;
        h_size_q     <= EXEC_SIZE;
        h_regwrite_q <= EXEC_REGWRITE;
        h_unsigned_q <= EXEC_UNSIGNED;
        h_store_q    <= EXEC_MEMWRITE;
      end
      if (retire_now) begin
        wb_pc4_q      <= EXEC_PC_4;
        wb_alu_q      <= EXEC_ALU_RESULT;
        wb_load_q     <= '0;
        wb_sel_q      <= EXEC_RF_WR_SEL;
        wb_regwrite_q <= EXEC_REGWRITE && !misalign;
        wb_misalign_q <= misalign;
        wb_bus_err_q  <= 1'b0;
      end else if (done) begin
        wb_pc4_q      <= h_pc4_q;
        wb_alu_q      <= h_alu_q;
        wb_load_q     <= (h_store_q || timeout) ? 32'b0 : align_load;
        wb_sel_q      <= h_sel_q;
        wb_regwrite_q <= h_regwrite_q && !timeout;
        wb_misalign_q <= 1'b0;
        wb_bus_err_q  <= timeout;
      end
    end
  end

  assign MEM_STALL      = (state_q == ACCESS);
  assign MEM_REQ        = req_q;
  assign MEM_WE         = we_q;
  assign MEM_ADDR       = addr_q;
  assign MEM_WDATA      = wdata_q;
  assign MEM_BE         = be_q;
  assign MEM_VALID      = wb_valid_q;
  assign MEM_PC_4       = wb_pc4_q;
  assign MEM_ALU_RESULT = wb_alu_q;
  assign MEM_LOAD_DATA  = wb_load_q;
  assign MEM_RF_WR_SEL  = wb_sel_q;
  assign MEM_REGWRITE   = wb_regwrite_q;
  assign MEM_MISALIGN   = wb_misalign_q;
  assign MEM_BUS_ERR    = wb_bus_err_q;

endmodule
